// File: rtl/cpld_uart_bridge_pkg.sv
// Shared definitions for the CPLD UART bridge.
// This file holds the RX/TX state encodings and the baud divider helpers.
package cpld_uart_bridge_pkg;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  // Clocks per serial bit, truncated. No fractional correction is applied.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Clocks from a start-bit edge to the middle of that start bit.
  function automatic int calc_half(input int div);
    return div / 2;
  endfunction

  // Bits needed to count 0..n-1. At least one bit is always returned.
  function automatic int addr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpld_uart_rx_fifo.sv
// Circular receive buffer for the CPLD UART bridge. It is used only when
// CPLD_UART_RX_FIFO_EN is defined.
// When the buffer is full, a push is dropped unless a pop happens in the same
// cycle. A push and a pop in the same cycle both take effect and leave the
// occupancy unchanged.
module cpld_uart_rx_fifo
  import cpld_uart_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = addr_bits(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [AW:0]   count;
  logic          full;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is written without a reset. Occupancy alone decides which
  // entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/cpld_uart_bridge.sv
// Responder side of the CPLD serial-controller handshake. It bridges the
// uart_rdn/uart_wrn strobes to an 8N1 UART on rxd/txd.
// Optional macro: CPLD_UART_RX_FIFO_EN selects a FIFO_DEPTH-entry RX FIFO.
// Without the macro, the RX buffer is a single-byte holding register.
module cpld_uart_bridge
  import cpld_uart_bridge_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       txd,
  input  logic       uart_rdn,
  input  logic       uart_wrn,
  output logic       uart_dataready,
  output logic       uart_tbre,
  output logic       uart_tsre,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       data_oe
);

  localparam int DIV  = calc_div(CLK_FREQ, BAUD);
  localparam int HALF = calc_half(DIV);
  localparam int CW   = addr_bits(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [1:0] rx_sync;
  logic       rx_s;
  logic       rx_prev;
  logic       rdn_prev;
  logic       wrn_prev;
  logic       rd_rise;
  logic       wr_rise;

  uart_state_e   rx_state, rx_next;
  logic [CW-1:0] rx_cnt, rx_cnt_next, rx_cnt_inc;
  logic [2:0]    rx_bit, rx_bit_next;
  logic [7:0]    rx_shift, rx_shift_next;
  logic          rx_push;

  uart_state_e   tx_state, tx_next;
  logic [CW-1:0] tx_cnt, tx_cnt_next, tx_cnt_inc;
  logic [2:0]    tx_bit, tx_bit_next;
  logic [7:0]    tx_shift, tx_shift_next;
  logic          tx_load;
  logic [7:0]    hold;
  logic          hold_full;

  logic       rx_empty;
  logic [7:0] rx_head;

  assign rx_s    = rx_sync[1];
  assign rd_rise = ~rdn_prev & uart_rdn;
  assign wr_rise = ~wrn_prev & uart_wrn;

  // Synchronise rxd and keep the previous strobe levels for edge detection.
  // Everything idles high, so it also resets high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rdn_prev <= 1'b1;
      wrn_prev <= 1'b1;
    end else begin
      rx_sync  <= {rx_sync[0], rxd};
      rx_prev  <= rx_s;
      rdn_prev <= uart_rdn;
      wrn_prev <= uart_wrn;
    end
  end

  // RX state register and datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= UART_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_next;
      rx_cnt   <= rx_cnt_next;
      rx_bit   <= rx_bit_next;
      rx_shift <= rx_shift_next;
    end
  end

  // RX next state. The start bit is rechecked at its midpoint, and each later
  // bit is sampled a whole bit period after the previous sample point.
  // Entry needs a falling edge, so after a framing error the FSM does not
  // re-arm until the line has been seen high again.
  always_comb begin
    rx_next       = rx_state;
    rx_cnt_inc    = (rx_cnt == CNT_LAST) ? '0 : rx_cnt + 1'b1;
    rx_cnt_next   = rx_cnt_inc;
    rx_bit_next   = rx_bit;
    rx_shift_next = rx_shift;
    rx_push       = 1'b0;
    case (rx_state)
      UART_IDLE: begin
        rx_cnt_next = '0;
        if (rx_prev && !rx_s) rx_next = UART_START;
      end
      UART_START: begin
        if (rx_cnt == CNT_HALF) begin
          rx_cnt_next = '0;
          rx_bit_next = '0;
          rx_next     = rx_s ? UART_IDLE : UART_DATA;
        end
      end
      UART_DATA: begin
        if (rx_cnt == CNT_LAST) begin
          rx_shift_next = {rx_s, rx_shift[7:1]};
          rx_bit_next   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_next = UART_STOP;
        end
      end
      UART_STOP: begin
        if (rx_cnt == CNT_LAST) begin
          rx_push = rx_s;
          rx_next = UART_IDLE;
        end
      end
      default: rx_next = UART_IDLE;
    endcase
  end

  // TX state register, shifter and CPU-facing holding register.
  // A write is accepted only when the holding register is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= UART_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      tx_state <= tx_next;
      tx_cnt   <= tx_cnt_next;
      tx_bit   <= tx_bit_next;
      tx_shift <= tx_shift_next;
      if (tx_load) begin
        hold_full <= 1'b0;
      end else if (wr_rise && !hold_full) begin
        hold      <= data_i;
        hold_full <= 1'b1;
      end
    end
  end

  // TX next state. A byte waiting at the end of the stop bit goes straight
  // into a new start bit, with no idle bit in between.
  always_comb begin
    tx_next       = tx_state;
    tx_cnt_inc    = (tx_cnt == CNT_LAST) ? '0 : tx_cnt + 1'b1;
    tx_cnt_next   = tx_cnt_inc;
    tx_bit_next   = tx_bit;
    tx_shift_next = tx_shift;
    tx_load       = 1'b0;
    case (tx_state)
      UART_IDLE: begin
        tx_cnt_next = '0;
        if (hold_full) begin
          tx_load = 1'b1;
          tx_next = UART_START;
        end
      end
      UART_START: begin
        if (tx_cnt == CNT_LAST) begin
          tx_bit_next = '0;
          tx_next     = UART_DATA;
        end
      end
      UART_DATA: begin
        if (tx_cnt == CNT_LAST) begin
          tx_shift_next = {1'b0, tx_shift[7:1]};
          tx_bit_next   = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_next = UART_STOP;
        end
      end
      UART_STOP: begin
        if (tx_cnt == CNT_LAST) begin
          if (hold_full) begin
            tx_load = 1'b1;
            tx_next = UART_START;
          end else begin
            tx_next = UART_IDLE;
          end
        end
      end
      default: tx_next = UART_IDLE;
    endcase
    if (tx_load) tx_shift_next = hold;
  end

  // Line level follows the TX state. Reset returns the FSM to IDLE, which
  // forces txd high at once.
  always_comb begin
    case (tx_state)
      UART_START: txd = 1'b0;
      UART_DATA:  txd = tx_shift[0];
      default:    txd = 1'b1;
    endcase
  end

`ifdef CPLD_UART_RX_FIFO_EN
  cpld_uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (rd_rise),
    .empty     (rx_empty),
    .head      (rx_head)
  );
`else
  logic [7:0] rx_hold;
  logic       rx_valid;
  logic       rx_do_pop;
  logic       rx_do_push;

  assign rx_do_pop  = rd_rise & rx_valid;
  assign rx_do_push = rx_push & (~rx_valid | rx_do_pop);
  assign rx_empty   = ~rx_valid;
  assign rx_head    = rx_hold;

  // Single-entry RX buffer. It follows the same full, pop and simultaneous
  // push/pop rules as the FIFO, with a depth of one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_hold  <= '0;
      rx_valid <= 1'b0;
    end else if (rx_do_push) begin
      rx_hold  <= rx_shift;
      rx_valid <= 1'b1;
    end else if (rx_do_pop) begin
      rx_valid <= 1'b0;
    end
  end
`endif

  assign uart_dataready = ~rx_empty;
  assign uart_tbre      = ~hold_full;
  assign uart_tsre      = (tx_state == UART_IDLE) & ~hold_full;
  assign data_oe        = ~uart_rdn;
  assign data_o         = rx_empty ? 8'h00 : rx_head;

endmodule

// File: tb/tb_cpld_uart_bridge.sv
// Directed testbench for cpld_uart_bridge at default parameters (DIV = 434).
// The expected RX count depends on whether CPLD_UART_RX_FIFO_EN is defined.
module tb_cpld_uart_bridge;

  localparam int DIV  = 434;
  localparam int HALF = 217;
`ifdef CPLD_UART_RX_FIFO_EN
  localparam int EXP_RX = 4;
`else
  localparam int EXP_RX = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       txd;
  logic       uart_rdn;
  logic       uart_wrn;
  logic       uart_dataready;
  logic       uart_tbre;
  logic       uart_tsre;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       data_oe;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic       mon_en = 1'b0;
  logic [7:0] mon_q[$];
  int         mon_start[$];
  logic       mon_ok[$];

  cpld_uart_bridge #(
    .CLK_FREQ   (50000000),
    .BAUD       (115200),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rxd            (rxd),
    .txd            (txd),
    .uart_rdn       (uart_rdn),
    .uart_wrn       (uart_wrn),
    .uart_dataready (uart_dataready),
    .uart_tbre      (uart_tbre),
    .uart_tsre      (uart_tsre),
    .data_i         (data_i),
    .data_o         (data_o),
    .data_oe        (data_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic writeByte(input logic [7:0] b);
    data_i   = b;
    uart_wrn = 1'b0;
    step(1);
    uart_wrn = 1'b1;
    step(1);
  endtask

  task automatic readByte(output logic oe, output logic [7:0] d);
    uart_rdn = 1'b0;
    step(1);
    oe = data_oe;
    d  = data_o;
    uart_rdn = 1'b1;
    step(1);
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    step(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      step(DIV);
    end
    rxd = stop_bit;
    step(DIV);
    rxd = 1'b1;
    step(DIV);
  endtask

  // Bench-side receiver on txd: it samples mid-bit and records each byte,
  // its start cycle and whether its framing is valid.
  initial begin : txMonitor
    int         t0;
    logic [7:0] b;
    logic       ok;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && txd === 1'b0) begin
        t0 = cyc;
        repeat (HALF) @(posedge clk);
        #1;
        ok = (txd === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(posedge clk);
          #1;
          b[i] = txd;
        end
        repeat (DIV) @(posedge clk);
        #1;
        ok = ok & (txd === 1'b1);
        mon_q.push_back(b);
        mon_start.push_back(t0);
        mon_ok.push_back(ok);
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : applyStimulus
    logic       oe;
    logic [7:0] d;
    logic [7:0] exp_b;
    logic [7:0] got_q[8];
    int         n;

    rst = 1'b1; rxd = 1'b1; uart_rdn = 1'b1; uart_wrn = 1'b1; data_i = 8'h00;
    step(3);
    rst = 1'b0;
    step(1);
    checkOutput("reset_txd", txd, 1);
    checkOutput("reset_tbre", uart_tbre, 1);
    checkOutput("reset_tsre", uart_tsre, 1);
    checkOutput("reset_dataready", uart_dataready, 0);
    checkOutput("reset_data_oe", data_oe, 0);
    checkOutput("reset_data_o", data_o, 0);

    // Transmit 0xA5 and check the start length and each bit at mid-bit.
    writeByte(8'hA5);
    checkOutput("tx_tbre_captured", uart_tbre, 0);
    n = 0;
    while (txd !== 1'b0 && n < 20) begin step(1); n++; end
    checkOutput("tx_start_seen", txd, 0);
    checkOutput("tx_tbre_loaded", uart_tbre, 1);
    checkOutput("tx_tsre_busy", uart_tsre, 0);
    n = 0;
    while (txd === 1'b0 && n < 2 * DIV) begin step(1); n++; end
    checkOutput("tx_start_len", n, DIV);
    exp_b = 8'hA5;
    step(HALF);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("tx_a5_bit%0d", i), txd, exp_b[i]);
      step(DIV);
    end
    checkOutput("tx_stop_bit", txd, 1);
    checkOutput("tx_tsre_in_stop", uart_tsre, 0);
    step(HALF + 2);
    checkOutput("tx_tsre_done", uart_tsre, 1);
    checkOutput("tx_idle_txd", txd, 1);

    // Reset in the middle of a frame.
    writeByte(8'h00);
    step(600);
    checkOutput("midtx_txd_low", txd, 0);
    checkOutput("midtx_tsre", uart_tsre, 0);
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(1);
    checkOutput("midrst_txd", txd, 1);
    checkOutput("midrst_tbre", uart_tbre, 1);
    checkOutput("midrst_tsre", uart_tsre, 1);
    checkOutput("midrst_dataready", uart_dataready, 0);

    // Receive 0x3C and read it back.
    sendFrame(8'h3C, 1'b1);
    checkOutput("rx_3c_dataready", uart_dataready, 1);
    readByte(oe, d);
    checkOutput("rx_3c_oe", oe, 1);
    checkOutput("rx_3c_data", d, 8'h3C);
    checkOutput("rx_3c_popped", uart_dataready, 0);
    checkOutput("rx_oe_released", data_oe, 0);

    // Read while empty.
    readByte(oe, d);
    checkOutput("rx_empty_data", d, 0);
    checkOutput("rx_empty_dataready", uart_dataready, 0);

    // Short low glitch, then a frame with a bad stop bit.
    rxd = 1'b0;
    step(100);
    rxd = 1'b1;
    step(DIV * 11);
    checkOutput("rx_glitch_no_byte", uart_dataready, 0);
    sendFrame(8'h7E, 1'b0);
    checkOutput("rx_framing_discard", uart_dataready, 0);
    sendFrame(8'h5A, 1'b1);
    checkOutput("rx_rearm_dataready", uart_dataready, 1);
    readByte(oe, d);
    checkOutput("rx_rearm_data", d, 8'h5A);

    // Overflow: five unread frames.
    for (int v = 1; v <= 5; v++) sendFrame(8'(v), 1'b1);
    n = 0;
    while (uart_dataready === 1'b1 && n < 8) begin
      readByte(oe, d);
      got_q[n] = d;
      n++;
    end
    checkOutput("rx_ovf_count", n, EXP_RX);
    for (int i = 0; i < EXP_RX; i++) begin
      if (i < n) checkOutput($sformatf("rx_ovf_byte%0d", i), got_q[i], i + 1);
      else       checkOutput($sformatf("rx_ovf_byte%0d", i), 32'hx, i + 1);
    end

    // Back-to-back frames. A write while the holding register is full is dropped.
    mon_en = 1'b1;
    writeByte(8'h55);
    n = 0;
    while (uart_tbre !== 1'b1 && n < 20) begin step(1); n++; end
    checkOutput("b2b_tbre_free", uart_tbre, 1);
    writeByte(8'h11);
    checkOutput("b2b_tbre_held", uart_tbre, 0);
    writeByte(8'h22);
    checkOutput("b2b_tbre_still_held", uart_tbre, 0);
    step(DIV * 24);
    mon_en = 1'b0;
    checkOutput("b2b_frame_count", mon_q.size(), 2);
    checkOutput("b2b_byte0", (mon_q.size() > 0) ? mon_q[0] : 8'hxx, 8'h55);
    checkOutput("b2b_byte1", (mon_q.size() > 1) ? mon_q[1] : 8'hxx, 8'h11);
    checkOutput("b2b_framing0", (mon_ok.size() > 0) ? mon_ok[0] : 1'bx, 1);
    checkOutput("b2b_framing1", (mon_ok.size() > 1) ? mon_ok[1] : 1'bx, 1);
    checkOutput("b2b_gap", (mon_start.size() > 1) ? mon_start[1] - mon_start[0] : -1, 10 * DIV);
    checkOutput("b2b_tsre_end", uart_tsre, 1);
    checkOutput("b2b_txd_end", txd, 1);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
